// File: rtl/calc_pkg.sv
// Shared calculator types plus a helper that sizes the BCD digit field for a binary width.
package calc_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef bit [3:0] bcd_digit_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  // Smallest digit count whose decimal range covers 2**width-1.
  function automatic int bcd_digits_needed(input int width);
    longint unsigned maxv;
    longint unsigned p;
    int              n;
    maxv = (64'd1 << width) - 64'd1;
    p    = 64'd10;
    n    = 1;
    for (int i = 0; i < 20; i++) begin
      if (p <= maxv) begin
        p = p * 64'd10;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_dabble_digit
  import calc_pkg::*;
(
  input  bcd_digit_t din,
  output bcd_digit_t dout
);

  always_comb begin
    dout = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;
  end

endmodule

// File: rtl/calc_result_to_bcd.sv
// Iterative binary-to-BCD converter (one bit per clock) with valid/ready on both sides.
// Define CALC_BCD_SIGNED_EN to treat in_result as two's complement and add out_negative.
module calc_result_to_bcd
  import calc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIGITS     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_result,
  input  logic                         in_invalid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          out_bcd,
  output logic                         out_error,
`ifdef CALC_BCD_SIGNED_EN
  output logic                         out_negative,
`endif
  output logic [$clog2(DIGITS+1)-1:0]  out_digits
);

  localparam int BW  = 4 * DIGITS;
  localparam int CW  = $clog2(DATA_WIDTH + 1);
  localparam int DGW = $clog2(DIGITS + 1);

  if (DIGITS < bcd_digits_needed(DATA_WIDTH)) begin : g_digits_too_small
    $error("calc_result_to_bcd: DIGITS cannot hold 2**DATA_WIDTH-1");
  end

  bcd_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW-1:0]         out_bcd_q, out_bcd_d;
  logic                  out_error_q, out_error_d;
  logic [DGW-1:0]        out_digits_q, out_digits_d;
`ifdef CALC_BCD_SIGNED_EN
  logic                  neg_q, neg_d;
  logic                  out_neg_q, out_neg_d;
`endif

  logic [BW-1:0]         bcd_corr;
  logic [BW-1:0]         bcd_shift;
  logic [DATA_WIDTH-1:0] mag;
  logic                  unused_corr_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_corr[4*g +: 4])
    );
  end

  // The corrected top bit is always 0 given the DIGITS constraint, so it falls off the shift.
  assign bcd_shift       = {bcd_corr[BW-2:0], shreg_q[DATA_WIDTH-1]};
  assign unused_corr_msb = bcd_corr[BW-1];

`ifdef CALC_BCD_SIGNED_EN
  assign mag = in_result[DATA_WIDTH-1] ? (~in_result + 1'b1) : in_result;
`else
  assign mag = in_result;
`endif

  function automatic logic [DGW-1:0] sig_digits(input logic [BW-1:0] b);
    logic [DGW-1:0] n;
    n = DGW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) n = DGW'(i + 1);
    end
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_bcd_d    = out_bcd_q;
    out_error_d  = out_error_q;
    out_digits_d = out_digits_q;
`ifdef CALC_BCD_SIGNED_EN
    neg_d        = neg_q;
    out_neg_d    = out_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_invalid) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            out_error_d  = 1'b1;
            out_bcd_d    = '0;
            out_digits_d = '0;
`ifdef CALC_BCD_SIGNED_EN
            out_neg_d    = 1'b0;
`endif
          end else begin
            state_d = SHIFT;
            shreg_d = mag;
            bcd_d   = '0;
            cnt_d   = CW'(DATA_WIDTH);
`ifdef CALC_BCD_SIGNED_EN
            neg_d   = in_result[DATA_WIDTH-1];
`endif
          end
        end
      end
      SHIFT: begin
        bcd_d   = bcd_shift;
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_error_d  = 1'b0;
          out_bcd_d    = bcd_shift;
          out_digits_d = sig_digits(bcd_shift);
`ifdef CALC_BCD_SIGNED_EN
          out_neg_d    = neg_q;
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_bcd_q    <= '0;
      out_error_q  <= 1'b0;
      out_digits_q <= '0;
`ifdef CALC_BCD_SIGNED_EN
      neg_q        <= 1'b0;
      out_neg_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_bcd_q    <= out_bcd_d;
      out_error_q  <= out_error_d;
      out_digits_q <= out_digits_d;
`ifdef CALC_BCD_SIGNED_EN
      neg_q        <= neg_d;
      out_neg_q    <= out_neg_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign out_bcd    = out_bcd_q;
  assign out_error  = out_error_q;
  assign out_digits = out_digits_q;
`ifdef CALC_BCD_SIGNED_EN
  assign out_negative = out_neg_q;
`endif

endmodule

// File: tb/tb_calc_result_to_bcd.sv
// Directed bench for calc_result_to_bcd with a decimal-arithmetic reference model checked every cycle.
module tb_calc_result_to_bcd;

  localparam int W   = 16;
  localparam int D   = 5;
  localparam int DGW = 3;
`ifdef CALC_BCD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_invalid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_result = '0;
  wire            in_ready;
  wire            out_valid;
  wire            out_error;
  wire [4*D-1:0]  out_bcd;
  wire [DGW-1:0]  out_digits;
`ifdef CALC_BCD_SIGNED_EN
  wire            out_negative;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  calc_result_to_bcd #(.DATA_WIDTH(W), .DIGITS(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_invalid (in_invalid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bcd    (out_bcd),
    .out_error  (out_error),
`ifdef CALC_BCD_SIGNED_EN
    .out_negative (out_negative),
`endif
    .out_digits (out_digits)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by repeated division, magnitude by plain arithmetic.
  function automatic int unsigned mag_of(input logic [W-1:0] r);
    int unsigned u;
    u = r;
    if (SGN && r[W-1]) u = (32'd1 << W) - u;
    return u;
  endfunction

  function automatic logic [4*D-1:0] to_bcd(input int unsigned v);
    logic [4*D-1:0] b;
    int unsigned    x;
    x = v;
    b = '0;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  function automatic int ndig(input int unsigned v);
    int unsigned x;
    int          n;
    x = v;
    n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return n;
  endfunction

  bit             m_busy = 1'b0;
  int             m_age = 0;
  int             m_lat = 0;
  logic [4*D-1:0] m_bcd = '0;
  bit             m_err = 1'b0;
  int             m_dig = 0;
  bit             m_neg = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_lat  <= in_invalid ? 0 : W;
        m_err  <= in_invalid;
        m_bcd  <= in_invalid ? '0 : to_bcd(mag_of(in_result));
        m_dig  <= in_invalid ? 0 : ndig(mag_of(in_result));
        m_neg  <= !in_invalid && SGN && in_result[W-1];
      end
    end else if (m_age >= m_lat && out_ready) begin
      m_busy <= 1'b0;
    end else if (m_age < 1000) begin
      m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (started && rst_n) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_busy && m_age >= m_lat);
      if (m_busy && m_age >= m_lat) begin
        chk("out_bcd", out_bcd, m_bcd);
        chk("out_error", out_error, m_err);
        chk("out_digits", out_digits, m_dig);
`ifdef CALC_BCD_SIGNED_EN
        chk("out_negative", out_negative, m_neg);
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input bit inv);
    bit ok;
    ok         = 1'b0;
    in_valid   = 1'b1;
    in_result  = v;
    in_invalid = inv;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid   = 1'b0;
    in_invalid = 1'b0;
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("valid_timeout", out_valid, 1'b1);
  endtask

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bcd", out_bcd, 20'h0);
    chk("rst_out_error", out_error, 1'b0);
    chk("rst_out_digits", out_digits, 3'd0);
    rst_n   = 1'b1;
    started = 1'b1;
    out_ready = 1'b1;

    send(16'd0, 1'b0);
    wait_valid(c);
    chk("lat_zero", c, 16);
    chk("zero_bcd", out_bcd, 20'h00000);
    chk("zero_digits", out_digits, 3'd1);
    chk("zero_error", out_error, 1'b0);
    @(posedge clk); #1;
    chk("zero_drop_valid", out_valid, 1'b0);

    send(16'hFFFF, 1'b0);
    wait_valid(c);
`ifdef CALC_BCD_SIGNED_EN
    chk("ffff_bcd", out_bcd, 20'h00001);
    chk("ffff_neg", out_negative, 1'b1);
    chk("ffff_digits", out_digits, 3'd1);
`else
    chk("ffff_bcd", out_bcd, 20'h65535);
    chk("ffff_digits", out_digits, 3'd5);
`endif
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(16'd1234, 1'b0);
    wait_valid(c);
    chk("hold_bcd0", out_bcd, 20'h01234);
    chk("hold_digits0", out_digits, 3'd4);
    in_valid  = 1'b1;
    in_result = 16'd4321;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_bcd", out_bcd, 20'h01234);
      chk("hold_digits", out_digits, 3'd4);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid_drop", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    chk("second_accepted", in_ready, 1'b0);
    in_valid = 1'b0;
    wait_valid(c);
    chk("second_bcd", out_bcd, 20'h04321);
    chk("second_digits", out_digits, 3'd4);
    @(posedge clk); #1;

    send(16'd7, 1'b1);
    chk("err_valid", out_valid, 1'b1);
    chk("err_flag", out_error, 1'b1);
    chk("err_bcd", out_bcd, 20'h0);
    chk("err_digits", out_digits, 3'd0);
    @(posedge clk); #1;

    send(16'd9999, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_valid", out_valid, 1'b0);
    send(16'd42, 1'b0);
    wait_valid(c);
    chk("lat_42", c, 16);
    chk("v42_bcd", out_bcd, 20'h00042);
    chk("v42_digits", out_digits, 3'd2);
    @(posedge clk); #1;

    send(16'h8000, 1'b0);
    wait_valid(c);
    chk("v8000_bcd", out_bcd, 20'h32768);
    chk("v8000_digits", out_digits, 3'd5);
`ifdef CALC_BCD_SIGNED_EN
    chk("v8000_neg", out_negative, 1'b1);
`endif
    @(posedge clk); #1;

    send(16'd100, 1'b0);
    wait_valid(c);
    chk("v100_bcd", out_bcd, 20'h00100);
    chk("v100_digits", out_digits, 3'd3);
    @(posedge clk); #1;

    send(16'd9, 1'b0);
    wait_valid(c);
    chk("v9_bcd", out_bcd, 20'h00009);
    chk("v9_digits", out_digits, 3'd1);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
